// File: rtl/pattern_sequencer.sv
// Multi-channel note pattern sequencer: each tick scans every channel, fetching its
// current pattern entry from a synchronous ROM and emitting registered note events.
module pattern_sequencer #(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 8,
  parameter  int NOTE_W = 6,
  parameter  int DUR_W  = 5,
  parameter  int INST_W = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DATA_W = NOTE_W + DUR_W + INST_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [CH_W-1:0]   i_cmd_ch,
  input  logic              i_cmd_stop,
  input  logic [ADDR_W-1:0] i_cmd_base,
  input  logic [ADDR_W-1:0] i_cmd_len,
  input  logic              i_cmd_loop,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic              o_note_valid,
  output logic [CH_W-1:0]   o_note_ch,
  output logic [NOTE_W-1:0] o_note,
  output logic [DUR_W-1:0]  o_note_dur,
  output logic [INST_W-1:0] o_note_inst,
  output logic [NUM_CH-1:0] o_ch_done,
  output logic              o_busy,
  output logic              o_overrun
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                pending_q, pending_d;

  logic [NUM_CH-1:0]   active_q, active_d;
  logic [NUM_CH-1:0]   first_q, first_d;
  logic [NUM_CH-1:0]   loop_q, loop_d;
  logic [ADDR_W-1:0]   base_q [NUM_CH];
  logic [ADDR_W-1:0]   base_d [NUM_CH];
  logic [ADDR_W-1:0]   len_q [NUM_CH];
  logic [ADDR_W-1:0]   len_d [NUM_CH];
  // One extra bit so a full-length pattern can still reach len+1.
  logic [ADDR_W:0]     index_q [NUM_CH];
  logic [ADDR_W:0]     index_d [NUM_CH];
  logic [DUR_W-1:0]    dur_cnt_q [NUM_CH];
  logic [DUR_W-1:0]    dur_cnt_d [NUM_CH];
  logic [DUR_W-1:0]    cur_dur_q [NUM_CH];
  logic [DUR_W-1:0]    cur_dur_d [NUM_CH];

  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                note_valid_q, note_valid_d;
  logic [CH_W-1:0]     note_ch_q, note_ch_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    note_dur_q, note_dur_d;
  logic [INST_W-1:0]   note_inst_q, note_inst_d;
  logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
  logic                overrun_q, overrun_d;

  logic                sel_active, sel_first, sel_loop;
  logic [ADDR_W-1:0]   sel_base, sel_len;
  logic [ADDR_W:0]     sel_index, eff_index;
  logic [DUR_W-1:0]    sel_cnt, sel_cur;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                past_end, note_due;

  always_comb begin
    sel_active = 1'b0;
    sel_first  = 1'b0;
    sel_loop   = 1'b0;
    sel_base   = '0;
    sel_len    = '0;
    sel_index  = '0;
    sel_cnt    = '0;
    sel_cur    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) begin
        sel_active = active_q[c];
        sel_first  = first_q[c];
        sel_loop   = loop_q[c];
        sel_base   = base_q[c];
        sel_len    = len_q[c];
        sel_index  = index_q[c];
        sel_cnt    = dur_cnt_q[c];
        sel_cur    = cur_dur_q[c];
      end
    end
    // A looping pattern that ran off its end restarts at entry 0 within this slot.
    past_end   = sel_index > {1'b0, sel_len};
    eff_index  = (past_end && sel_loop) ? '0 : sel_index;
    fetch_addr = sel_base + eff_index[ADDR_W-1:0];
    note_due   = sel_first || (sel_cnt == sel_cur);
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    pending_d    = pending_q;
    active_d     = active_q;
    first_d      = first_q;
    loop_d       = loop_q;
    base_d       = base_q;
    len_d        = len_q;
    index_d      = index_q;
    dur_cnt_d    = dur_cnt_q;
    cur_dur_d    = cur_dur_q;
    rom_addr_d   = rom_addr_q;
    note_valid_d = 1'b0;
    note_ch_d    = note_ch_q;
    note_d       = note_q;
    note_dur_d   = note_dur_q;
    note_inst_d  = note_inst_q;
    ch_done_d    = '0;
    overrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (i_cmd_ch == CH_W'(c)) begin
              if (i_cmd_stop) begin
                active_d[c] = 1'b0;
              end else begin
                active_d[c]  = 1'b1;
                first_d[c]   = 1'b1;
                loop_d[c]    = i_cmd_loop;
                base_d[c]    = i_cmd_base;
                len_d[c]     = i_cmd_len;
                index_d[c]   = '0;
                dur_cnt_d[c] = '0;
              end
            end
          end
        end
        if (i_tick || pending_q) begin
          state_d   = ADDR;
          ch_d      = '0;
          pending_d = pending_q && i_tick;
        end
      end
      ADDR: begin
        rom_addr_d = fetch_addr;
        state_d    = DATA;
      end
      DATA: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_q == CH_W'(c) && sel_active) begin
            if (!note_due) begin
              dur_cnt_d[c] = sel_cnt + 1'b1;
            end else if (!past_end || sel_loop) begin
              note_valid_d = 1'b1;
              note_ch_d    = ch_q;
              note_d       = i_rom_data[NOTE_W-1:0];
              note_dur_d   = i_rom_data[NOTE_W +: DUR_W];
              note_inst_d  = i_rom_data[NOTE_W+DUR_W +: INST_W];
              cur_dur_d[c] = i_rom_data[NOTE_W +: DUR_W];
              dur_cnt_d[c] = '0;
              first_d[c]   = 1'b0;
              index_d[c]   = eff_index + 1'b1;
            end else begin
              active_d[c]  = 1'b0;
              ch_done_d[c] = 1'b1;
            end
          end
        end
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only one tick can wait behind a running scan; any further one is reported.
    if (state_q != IDLE && i_tick) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      pending_q    <= 1'b0;
      active_q     <= '0;
      first_q      <= '0;
      loop_q       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        base_q[c]    <= '0;
        len_q[c]     <= '0;
        index_q[c]   <= '0;
        dur_cnt_q[c] <= '0;
        cur_dur_q[c] <= '0;
      end
      rom_addr_q   <= '0;
      note_valid_q <= 1'b0;
      note_ch_q    <= '0;
      note_q       <= '0;
      note_dur_q   <= '0;
      note_inst_q  <= '0;
      ch_done_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      first_q      <= first_d;
      loop_q       <= loop_d;
      base_q       <= base_d;
      len_q        <= len_d;
      index_q      <= index_d;
      dur_cnt_q    <= dur_cnt_d;
      cur_dur_q    <= cur_dur_d;
      rom_addr_q   <= rom_addr_d;
      note_valid_q <= note_valid_d;
      note_ch_q    <= note_ch_d;
      note_q       <= note_d;
      note_dur_q   <= note_dur_d;
      note_inst_q  <= note_inst_d;
      ch_done_q    <= ch_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_rom_addr   = (state_q == ADDR) ? fetch_addr : rom_addr_q;
  assign o_note_valid = note_valid_q;
  assign o_note_ch    = note_ch_q;
  assign o_note       = note_q;
  assign o_note_dur   = note_dur_q;
  assign o_note_inst  = note_inst_q;
  assign o_ch_done    = ch_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed pattern scenarios plus random ticks/commands,
// every cycle compared against a tick-level behavioural model of the sequencer.
module tb_pattern_sequencer;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 8;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 5;
  localparam int INST_W = 4;
  localparam int CH_W   = 2;
  localparam int DATA_W = NOTE_W + DUR_W + INST_W;
  localparam int SCAN   = 2 * NUM_CH;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic              i_rst, i_tick, i_cmd_valid, o_cmd_ready;
  logic [CH_W-1:0]   i_cmd_ch;
  logic              i_cmd_stop, i_cmd_loop;
  logic [ADDR_W-1:0] i_cmd_base, i_cmd_len;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [DATA_W-1:0] i_rom_data;
  logic              o_note_valid;
  logic [CH_W-1:0]   o_note_ch;
  logic [NOTE_W-1:0] o_note;
  logic [DUR_W-1:0]  o_note_dur;
  logic [INST_W-1:0] o_note_inst;
  logic [NUM_CH-1:0] o_ch_done;
  logic              o_busy, o_overrun;

  pattern_sequencer #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .INST_W(INST_W)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_ch(i_cmd_ch),
    .i_cmd_stop(i_cmd_stop), .i_cmd_base(i_cmd_base), .i_cmd_len(i_cmd_len),
    .i_cmd_loop(i_cmd_loop), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_note_valid(o_note_valid), .o_note_ch(o_note_ch), .o_note(o_note),
    .o_note_dur(o_note_dur), .o_note_inst(o_note_inst), .o_ch_done(o_ch_done),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  logic [DATA_W-1:0] rom_mem [256];
  always @(posedge i_clk) i_rom_data <= rom_mem[o_rom_addr];

  int cyc = 0;
  int vec_cnt = 0;
  int err_cnt = 0;

  // Behavioural model: per-channel pattern state, evaluated a whole scan at a time.
  bit m_active [NUM_CH];
  bit m_first  [NUM_CH];
  bit m_loop   [NUM_CH];
  int m_base   [NUM_CH];
  int m_len    [NUM_CH];
  int m_idx    [NUM_CH];
  int m_left   [NUM_CH];
  bit m_pending;
  int scan_start = -1;

  logic [CH_W+DATA_W-1:0] exp_note [int];
  logic [NUM_CH-1:0]      exp_done [int];
  int                     exp_addr [int];
  bit                     exp_ovr  [int];
  logic [CH_W+DATA_W-1:0] exp_last;

  int obs_note_cnt = 0, obs_done_cnt = 0, obs_ovr_cnt = 0, obs_busy_cnt = 0;
  int note_cyc [NUM_CH];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic bit modelBusy(input int t);
    return scan_start >= 0 && t >= scan_start && t < scan_start + SCAN;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_active[k] = 0; m_first[k] = 0; m_loop[k] = 0;
      m_base[k] = 0; m_len[k] = 0; m_idx[k] = 0; m_left[k] = 0;
    end
    m_pending  = 0;
    scan_start = -1;
    exp_note.delete();
    exp_done.delete();
    exp_addr.delete();
    exp_ovr.delete();
    exp_last = '0;
  endtask

  task automatic evalScan(input int s);
    scan_start = s;
    for (int k = 0; k < NUM_CH; k++) begin
      int eff;
      int a;
      logic [DATA_W-1:0] w;
      eff = (m_idx[k] > m_len[k] && m_loop[k]) ? 0 : m_idx[k];
      a   = (m_base[k] + eff) % 256;
      exp_addr[s + 2*k] = a;
      if (m_active[k]) begin
        if (m_first[k] || m_left[k] == 0) begin
          if (eff <= m_len[k]) begin
            w = rom_mem[a];
            exp_note[s + 2*k + 2] = {CH_W'(k), w};
            m_left[k]  = int'(w[NOTE_W +: DUR_W]);
            m_first[k] = 0;
            m_idx[k]   = eff + 1;
          end else begin
            m_active[k] = 0;
            exp_done[s + 2*k + 2] = NUM_CH'(1) << k;
          end
        end else begin
          m_left[k]--;
        end
      end
    end
  endtask

  task automatic modelCycle(output bit accepted);
    int t = cyc;
    bit idle;
    accepted = 0;
    if (i_rst) begin
      modelReset();
      return;
    end
    idle = !modelBusy(t);
    if (idle && i_cmd_valid) begin
      int k = int'(i_cmd_ch);
      accepted = 1;
      if (i_cmd_stop) m_active[k] = 0;
      else begin
        m_active[k] = 1; m_first[k] = 1; m_loop[k] = i_cmd_loop;
        m_base[k] = int'(i_cmd_base); m_len[k] = int'(i_cmd_len);
        m_idx[k] = 0; m_left[k] = 0;
      end
    end
    if (idle) begin
      if (i_tick || m_pending) begin
        evalScan(t + 1);
        m_pending = m_pending && i_tick;
      end
    end else if (i_tick) begin
      if (m_pending) exp_ovr[t + 1] = 1;
      else           m_pending = 1;
    end
  endtask

  task automatic checkCycle();
    bit b = modelBusy(cyc);
    checkOutput("busy", o_busy, b);
    checkOutput("cmd_ready", o_cmd_ready, !b);
    checkOutput("note_valid", o_note_valid, exp_note.exists(cyc));
    if (exp_note.exists(cyc)) exp_last = exp_note[cyc];
    checkOutput("note_fields", {o_note_ch, o_note_inst, o_note_dur, o_note}, exp_last);
    checkOutput("ch_done", o_ch_done, exp_done.exists(cyc) ? exp_done[cyc] : '0);
    checkOutput("overrun", o_overrun, exp_ovr.exists(cyc));
    if (b && ((cyc - scan_start) % 2 == 0))
      checkOutput("rom_addr", o_rom_addr, exp_addr.exists(cyc) ? exp_addr[cyc] : -1);
    if (o_note_valid === 1'b1) begin
      obs_note_cnt++;
      note_cyc[o_note_ch] = cyc;
    end
    if (|o_ch_done) obs_done_cnt++;
    if (o_overrun === 1'b1) obs_ovr_cnt++;
    if (o_busy === 1'b1) obs_busy_cnt++;
  endtask

  task automatic applyStimulus(input bit tick, output bit accepted);
    i_tick = tick;
    modelCycle(accepted);
    @(posedge i_clk);
    #1;
    cyc++;
    i_tick = 1'b0;
    checkCycle();
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) applyStimulus(1'b0, acc);
  endtask

  task automatic issueCommand(input int ch, input bit stop, input int base, input int len, input bit lp);
    bit acc = 0;
    int n = 0;
    i_cmd_valid = 1'b1;
    i_cmd_ch    = CH_W'(ch);
    i_cmd_stop  = stop;
    i_cmd_base  = ADDR_W'(base);
    i_cmd_len   = ADDR_W'(len);
    i_cmd_loop  = lp;
    while (!acc && n < 200) begin
      applyStimulus(1'b0, acc);
      n++;
    end
    i_cmd_valid = 1'b0;
    if (!acc) checkOutput("cmd_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    bit acc;
    logic [5:0] notes_seen, done_seen;
    logic [ADDR_W-1:0] got_addr [4];
    logic [ADDR_W-1:0] want_addr [4];
    int t0, n0, d0, b0, o0;

    i_rst = 1'b1; i_tick = 1'b0; i_cmd_valid = 1'b0; i_cmd_ch = '0; i_cmd_stop = 1'b0;
    i_cmd_base = '0; i_cmd_len = '0; i_cmd_loop = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = DATA_W'($urandom);
      rom_mem[i][NOTE_W +: DUR_W] = DUR_W'($urandom_range(0, 3));
    end
    rom_mem['h10][NOTE_W +: DUR_W] = 0;
    rom_mem['h11][NOTE_W +: DUR_W] = 1;
    rom_mem['h12][NOTE_W +: DUR_W] = 0;
    rom_mem['hFE][NOTE_W +: DUR_W] = 0;
    rom_mem['hFF][NOTE_W +: DUR_W] = 0;
    rom_mem['h00][NOTE_W +: DUR_W] = 0;
    rom_mem['h01][NOTE_W +: DUR_W] = 0;

    applyStimulus(1'b0, acc);
    applyStimulus(1'b0, acc);
    i_rst = 1'b0;
    checkOutput("rst_ready", o_cmd_ready, 1);
    checkOutput("rst_rom_addr", o_rom_addr, 0);
    idle(2);

    // One-shot three-entry pattern, then the same pattern looping.
    for (int pass = 0; pass < 2; pass++) begin
      issueCommand(0, 0, 'h10, 2, pass[0]);
      for (int t = 0; t < 6; t++) begin
        n0 = obs_note_cnt; d0 = obs_done_cnt;
        applyStimulus(1'b1, acc);
        idle(SCAN + 1);
        notes_seen[t] = (obs_note_cnt != n0);
        done_seen[t]  = (obs_done_cnt != d0);
      end
      checkOutput(pass == 0 ? "oneshot_notes" : "loop_notes", notes_seen, pass == 0 ? 6'b001011 : 6'b111011);
      checkOutput(pass == 0 ? "oneshot_done" : "loop_done", done_seen, pass == 0 ? 6'b010000 : 6'b000000);
    end

    // Channels 0 and 3 active: note latency per slot and busy window.
    issueCommand(0, 0, 'h20, 0, 1);
    issueCommand(3, 0, 'h30, 0, 1);
    for (int k = 0; k < NUM_CH; k++) note_cyc[k] = -1;
    t0 = cyc; b0 = obs_busy_cnt;
    applyStimulus(1'b1, acc);
    idle(SCAN + 2);
    checkOutput("ch0_latency", note_cyc[0] - t0, 3);
    checkOutput("ch3_latency", note_cyc[3] - t0, 9);
    checkOutput("busy_cycles", obs_busy_cnt - b0, SCAN);

    // Base near the top of the ROM wraps through address 0.
    issueCommand(0, 1, 0, 0, 0);
    issueCommand(3, 1, 0, 0, 0);
    issueCommand(1, 0, 'hFE, 3, 0);
    want_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, acc);
      idle(2);
      got_addr[i] = o_rom_addr;
      idle(SCAN - 1);
    end
    for (int i = 0; i < 4; i++) checkOutput("wrap_addr", got_addr[i], want_addr[i]);

    // Three ticks in one scan: one queued, one dropped with an overrun pulse.
    issueCommand(1, 1, 0, 0, 0);
    issueCommand(2, 0, 'h50, 1, 1);
    o0 = obs_ovr_cnt; b0 = obs_busy_cnt;
    applyStimulus(1'b1, acc);
    applyStimulus(1'b0, acc);
    applyStimulus(1'b1, acc);
    applyStimulus(1'b0, acc);
    applyStimulus(1'b1, acc);
    idle(20);
    checkOutput("overrun_pulses", obs_ovr_cnt - o0, 1);
    checkOutput("queued_scan_busy", obs_busy_cnt - b0, 2 * SCAN);

    // Command held across a scan is taken on the first idle cycle.
    t0 = cyc;
    applyStimulus(1'b1, acc);
    issueCommand(2, 1, 0, 0, 0);
    checkOutput("held_cmd_accept", cyc - t0, SCAN + 2);
    n0 = obs_note_cnt; d0 = obs_done_cnt;
    applyStimulus(1'b1, acc);
    idle(SCAN + 2);
    checkOutput("stopped_notes", obs_note_cnt - n0, 0);
    checkOutput("stopped_done", obs_done_cnt - d0, 0);

    // Reset during the data slot of channel 0 suppresses its note.
    issueCommand(0, 0, 'h10, 2, 1);
    n0 = obs_note_cnt;
    applyStimulus(1'b1, acc);
    applyStimulus(1'b0, acc);
    i_rst = 1'b1;
    applyStimulus(1'b0, acc);
    i_rst = 1'b0;
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_note_valid", o_note_valid, 0);
    checkOutput("midrst_note", {o_note_ch, o_note_inst, o_note_dur, o_note}, 0);
    checkOutput("midrst_rom_addr", o_rom_addr, 0);
    idle(SCAN + 4);
    checkOutput("midrst_notes", obs_note_cnt - n0, 0);

    // Random ticks, commands and occasional resets against the model.
    for (int n = 0; n < 3000; n++) begin
      if (!i_cmd_valid && $urandom_range(0, 7) == 0) begin
        i_cmd_valid = 1'b1;
        i_cmd_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
        i_cmd_stop  = ($urandom_range(0, 3) == 0);
        i_cmd_base  = ADDR_W'($urandom_range(0, 255));
        i_cmd_len   = ADDR_W'($urandom_range(0, 4));
        i_cmd_loop  = ($urandom_range(0, 1) == 1);
      end
      i_rst = ($urandom_range(0, 599) == 0);
      applyStimulus($urandom_range(0, 5) == 0, acc);
      i_rst = 1'b0;
      if (acc) i_cmd_valid = 1'b0;
    end
    i_cmd_valid = 1'b0;
    idle(2 * SCAN + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
